// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register numbers for rename, with a committed head
// pointer so a flush hands every speculatively allocated register back out in order.
module phys_reg_free_list #(
   parameter int  NUM_PHYS_REGS = 64,
   parameter int  NUM_ARCH_REGS = 35,
   localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                Alloc_req_IN,
   output logic                Alloc_valid_OUT,
   output logic [LOG_PHYS-1:0] Alloc_reg_OUT,
   input  logic                Free_IN,
   input  logic [LOG_PHYS-1:0] Free_reg_IN,
   input  logic                Commit_IN,
   input  logic                Flush_IN,
   output logic [LOG_PHYS:0]   Count_OUT,
   output logic                Empty_OUT,
   output logic                Overflow_err_OUT
);

   localparam int              PW        = LOG_PHYS + 1;
   localparam int              FREE_INIT = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam logic [PW-1:0]   DEPTH     = PW'(NUM_PHYS_REGS);
   localparam logic [PW-1:0]   INIT_TAIL = PW'(FREE_INIT);

   logic [LOG_PHYS-1:0] mem [NUM_PHYS_REGS];

   logic [PW-1:0] head_reg, head_next;
   logic [PW-1:0] commit_head_reg, commit_head_next;
   logic [PW-1:0] tail_reg, tail_next;
   logic          err_reg, err_next;

   logic [PW-1:0] count;
   logic [PW-1:0] head_after_alloc;
   logic          empty, full;
   logic          alloc_valid, alloc_fire;
   logic          free_ok, commit_ok;

   assign count       = tail_reg - head_reg;
   assign empty       = (count == '0);
   assign full        = (count == DEPTH);
   assign alloc_valid = !empty && !Flush_IN;
   assign alloc_fire  = Alloc_req_IN && alloc_valid;

   // A full list still takes a free when the head slot is vacated in the same cycle.
   assign free_ok     = Free_IN && (!full || alloc_fire);

   // A commit is legal only if some allocation, including this cycle's, is still uncommitted.
   assign head_after_alloc = head_reg + {{(PW-1){1'b0}}, alloc_fire};
   assign commit_ok        = Commit_IN && (commit_head_reg != head_after_alloc);

   always_comb begin
      commit_head_next = commit_head_reg + {{(PW-1){1'b0}}, commit_ok};
      tail_next        = tail_reg + {{(PW-1){1'b0}}, free_ok};
      head_next        = Flush_IN ? commit_head_next : head_after_alloc;
      err_next         = err_reg | (Free_IN && !free_ok) | (Commit_IN && !commit_ok);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head_reg        <= '0;
         commit_head_reg <= '0;
         tail_reg        <= INIT_TAIL;
         err_reg         <= 1'b0;
         for (int i = 0; i < NUM_PHYS_REGS; i++) begin
            mem[i] <= (i < FREE_INIT) ? LOG_PHYS'(NUM_ARCH_REGS + i) : '0;
         end
      end else begin
         head_reg        <= head_next;
         commit_head_reg <= commit_head_next;
         tail_reg        <= tail_next;
         err_reg         <= err_next;
         if (free_ok) begin
            mem[tail_reg[LOG_PHYS-1:0]] <= Free_reg_IN;
         end
      end
   end

   assign Alloc_valid_OUT  = alloc_valid;
   assign Alloc_reg_OUT    = empty ? '0 : mem[head_reg[LOG_PHYS-1:0]];
   assign Count_OUT        = count;
   assign Empty_OUT        = empty;
   assign Overflow_err_OUT = err_reg;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboarded bench for phys_reg_free_list: a queue-based model of the free pool
// predicts every cycle's outputs; a separate monitor compares them mid-cycle.
module tb_phys_reg_free_list;

   logic       CLK;
   logic       RESET;
   logic       Alloc_req_IN;
   logic       Alloc_valid_OUT;
   logic [5:0] Alloc_reg_OUT;
   logic       Free_IN;
   logic [5:0] Free_reg_IN;
   logic       Commit_IN;
   logic       Flush_IN;
   logic [6:0] Count_OUT;
   logic       Empty_OUT;
   logic       Overflow_err_OUT;

   phys_reg_free_list #(.NUM_PHYS_REGS(64), .NUM_ARCH_REGS(35)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .Alloc_req_IN     (Alloc_req_IN),
      .Alloc_valid_OUT  (Alloc_valid_OUT),
      .Alloc_reg_OUT    (Alloc_reg_OUT),
      .Free_IN          (Free_IN),
      .Free_reg_IN      (Free_reg_IN),
      .Commit_IN        (Commit_IN),
      .Flush_IN         (Flush_IN),
      .Count_OUT        (Count_OUT),
      .Empty_OUT        (Empty_OUT),
      .Overflow_err_OUT (Overflow_err_OUT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      int   cyc;
      logic valid;
      int   rnum;
      int   count;
      logic empty;
      logic err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_num  = 0;

   // Reference model: the ordered pool of free registers, the ordered list of
   // allocated-but-uncommitted registers, and the architecturally mapped set.
   int   free_q[$];
   int   inflight_q[$];
   int   in_use[$];
   logic err_m;

   task automatic model_reset();
      free_q.delete();
      inflight_q.delete();
      in_use.delete();
      for (int i = 35; i < 64; i++) free_q.push_back(i);
      for (int i = 0; i < 35; i++) in_use.push_back(i);
      err_m = 1'b0;
   endtask

   task automatic model_update(input bit req, input bit fr, input int freg, input bit cm, input bit fl);
      bit fire;
      bit was_full;
      int r;
      fire     = req && (free_q.size() != 0) && !fl;
      was_full = (free_q.size() == 64);
      if (fire) begin
         r = free_q.pop_front();
         inflight_q.push_back(r);
      end
      if (fr) begin
         if (!was_full || fire) free_q.push_back(freg);
         else err_m = 1'b1;
      end
      if (cm) begin
         if (inflight_q.size() != 0) begin
            r = inflight_q.pop_front();
            in_use.push_back(r);
         end else begin
            err_m = 1'b1;
         end
      end
      if (fl) begin
         // Uncommitted registers go back to the front of the pool in original order.
         for (int i = inflight_q.size() - 1; i >= 0; i--) free_q.push_front(inflight_q[i]);
         inflight_q.delete();
      end
   endtask

   task automatic do_cycle(input bit rst, input bit req, input bit fr, input int freg,
                           input bit cm, input bit fl);
      exp_t e;
      @(negedge CLK);
      RESET        = !rst;
      Alloc_req_IN = req;
      Free_IN      = fr;
      Free_reg_IN  = 6'(freg);
      Commit_IN    = cm;
      Flush_IN     = fl;
      cyc_num++;
      if (rst) model_reset();
      e.cyc   = cyc_num;
      e.valid = (free_q.size() != 0) && !fl;
      e.rnum  = (free_q.size() != 0) ? free_q[0] : 0;
      e.count = free_q.size();
      e.empty = (free_q.size() == 0);
      e.err   = err_m;
      exp_q.push_back(e);
      if (!rst) model_update(req, fr, freg, cm, fl);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0);
   endtask

   task automatic check(input string name, input int act, input int expv, input int cyc);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
      end
   endtask

   // Monitor: samples the combinational outputs mid-cycle, after the stimulus has settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("cyc %0d valid=%b reg=%0d count=%0d empty=%b err=%b",
                     e.cyc, Alloc_valid_OUT, Alloc_reg_OUT, Count_OUT, Empty_OUT, Overflow_err_OUT);
            check("alloc_valid", int'(Alloc_valid_OUT), int'(e.valid), e.cyc);
            check("alloc_reg",   int'(Alloc_reg_OUT),   e.rnum,        e.cyc);
            check("count",       int'(Count_OUT),       e.count,       e.cyc);
            check("empty",       int'(Empty_OUT),       int'(e.empty), e.cyc);
            check("overflow_err", int'(Overflow_err_OUT), int'(e.err), e.cyc);
         end
      end
   end

   initial begin
      int r_idx;
      int r_reg;
      bit req, fr, cm, fl;
      RESET        = 1'b0;
      Alloc_req_IN = 1'b0;
      Free_IN      = 1'b0;
      Free_reg_IN  = '0;
      Commit_IN    = 1'b0;
      Flush_IN     = 1'b0;
      model_reset();

      // Reset values, then drain the list with one request too many.
      do_cycle(1, 0, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 30; i++) do_cycle(0, 1, 0, 0, 0, 0);
      idle(1);

      // Empty: same-cycle free is not bypassed; then alloc+free keeps count.
      do_cycle(0, 1, 1, 40, 0, 0);
      do_cycle(0, 1, 1, 41, 0, 0);
      idle(2);

      // Commit one of three allocations, then flush.
      do_cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 0, 1, 0);
      do_cycle(0, 0, 0, 0, 0, 1);
      idle(2);

      // Fill to 64, drop a free, sticky flag; an illegal commit too.
      do_cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 35; i++) do_cycle(0, 0, 1, i, 0, 0);
      idle(1);
      do_cycle(0, 0, 1, 5, 0, 0);
      idle(3);
      do_cycle(1, 0, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 0, 1, 0);
      idle(2);

      // Full list with alloc+free in the same cycle accepts the free.
      do_cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 35; i++) do_cycle(0, 0, 1, i, 0, 0);
      do_cycle(0, 1, 1, 7, 0, 0);
      idle(1);

      // Randomized legal traffic with a mid-run asynchronous reset.
      do_cycle(1, 0, 0, 0, 0, 0);
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            do_cycle(1, 0, 0, 0, 0, 0);
            continue;
         end
         req = ($urandom_range(0, 3) != 0);
         cm  = (inflight_q.size() != 0) && ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 15) == 0);
         fr  = (in_use.size() != 0) && ($urandom_range(0, 2) != 0);
         r_reg = 0;
         if (fr) begin
            r_idx = $urandom_range(0, in_use.size() - 1);
            r_reg = in_use[r_idx];
            in_use.delete(r_idx);
         end
         do_cycle(0, req, fr, r_reg, cm, fl);
      end
      idle(1);

      repeat (3) @(negedge CLK);
      #4;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
